// File: rtl/tpu_package.sv
// Shared TPU definitions: array dimension, weight width and the weight row
// type consumed by both the weight FIFO and the systolic array weight input.
package tpu_package;

  localparam int unsigned MUL_SIZE = 8;
  localparam int unsigned WEIGHT_W = 8;

  typedef logic [MUL_SIZE*WEIGHT_W-1:0] weight_row_t;

endpackage

// File: rtl/weight_fifo_mem.sv
// Simple dual-port row store for weight_fifo: one write port, one
// registered read port, no reset on the array or the read register.
module weight_fifo_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = 3
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Row write and synchronous row read.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/weight_fifo.sv
// Tile-granular weight FIFO feeding the systolic MAC array.
// Rows are written from the host/DMA port; complete tiles are claimed by the
// control unit and drained one row per cycle while load_weights_i is high.
// Optional feature macro: WEIGHT_FIFO_ERR_EN adds sticky err_underflow_o and
// err_gap_o outputs.
module weight_fifo #(
  parameter int unsigned MUL_SIZE    = tpu_package::MUL_SIZE,
  parameter int unsigned WEIGHT_W    = tpu_package::WEIGHT_W,
  parameter int unsigned DEPTH_TILES = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_valid_i,
  input  logic [MUL_SIZE*WEIGHT_W-1:0] wr_data_i,
  output logic                         wr_ready_o,
  input  logic                         load_weights_i,
  output logic                         weight_fifo_valid_output,
  output logic [MUL_SIZE*WEIGHT_W-1:0] weight_row_o,
  output logic                         weight_row_valid_o
`ifdef WEIGHT_FIFO_ERR_EN
  ,
  output logic                         err_underflow_o,
  output logic                         err_gap_o
`endif
);

  localparam int unsigned ROW_W = MUL_SIZE * WEIGHT_W;
  localparam int unsigned DEPTH = DEPTH_TILES * MUL_SIZE;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW    = $clog2(DEPTH + 1);
  localparam int unsigned RW    = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;
  localparam int unsigned TW    = $clog2(DEPTH_TILES + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(MUL_SIZE - 1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [RW-1:0]   wr_row_q, wr_row_d;
  logic [RW-1:0]   rd_row_q, rd_row_d;
  logic [TW-1:0]   avail_q, avail_d;
  logic            ready_q;
  logic            tile_valid_q;
  logic            row_valid_q;
  logic            push, pop, claim, tile_done;
  logic [ROW_W-1:0] rd_data;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + AW'(1);
  endfunction

  assign push = wr_valid_i && ready_q;

  // Read FSM next state, pop/claim decode and counter updates.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    claim     = 1'b0;
    rd_row_d  = rd_row_q;
    tile_done = push && (wr_row_q == LAST_ROW);
    unique case (state_q)
      IDLE: begin
        if (load_weights_i && (avail_q != '0)) begin
          claim = 1'b1;
          pop   = 1'b1;
          // A one-row tile is finished by the claiming pop itself.
          if (MUL_SIZE > 1) begin
            state_d  = DRAIN;
            rd_row_d = RW'(1);
          end else begin
            rd_row_d = '0;
          end
        end
      end
      DRAIN: begin
        if (load_weights_i) begin
          pop = 1'b1;
          if (rd_row_q == LAST_ROW) begin
            state_d  = IDLE;
            rd_row_d = '0;
          end else begin
            rd_row_d = rd_row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? next_addr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_addr(rd_ptr_q) : rd_ptr_q;
    wr_row_d = wr_row_q;
    if (push) begin
      wr_row_d = tile_done ? '0 : wr_row_q + RW'(1);
    end
    occ_d   = occ_q + OW'(push) - OW'(pop);
    avail_d = avail_q + TW'(tile_done) - TW'(claim);
  end

  // State, pointers, counters and registered status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      wr_row_q     <= '0;
      rd_row_q     <= '0;
      avail_q      <= '0;
      ready_q      <= 1'b1;
      tile_valid_q <= 1'b0;
      row_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      wr_row_q     <= wr_row_d;
      rd_row_q     <= rd_row_d;
      avail_q      <= avail_d;
      ready_q      <= (occ_d < OW'(DEPTH));
      tile_valid_q <= (avail_d != '0);
      row_valid_q  <= pop;
    end
  end

  weight_fifo_mem #(
    .DATA_W (ROW_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data_i),
    .rd_en_i   (pop),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  // The RAM read register has no reset, so the row is gated by its valid
  // flag to present zero out of reset and between pops.
  assign weight_row_o             = row_valid_q ? rd_data : '0;
  assign weight_row_valid_o       = row_valid_q;
  assign wr_ready_o               = ready_q;
  assign weight_fifo_valid_output = tile_valid_q;

`ifdef WEIGHT_FIFO_ERR_EN
  logic err_underflow_q, err_gap_q;

  // Sticky protocol errors: pop request with nothing claimable, or a
  // request that drops mid-tile.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_underflow_q <= 1'b0;
      err_gap_q       <= 1'b0;
    end else begin
      if ((state_q == IDLE) && load_weights_i && (avail_q == '0)) begin
        err_underflow_q <= 1'b1;
      end
      if ((state_q == DRAIN) && !load_weights_i) begin
        err_gap_q <= 1'b1;
      end
    end
  end

  assign err_underflow_o = err_underflow_q;
  assign err_gap_o       = err_gap_q;
`endif

endmodule

// File: tb/tb_weight_fifo.sv
// Self-checking bench for weight_fifo (MUL_SIZE=4, DEPTH_TILES=2).
// Expected rows are queued when a pop is requested; a monitor compares every
// presented row against the queue.
module tb_weight_fifo;

  localparam int unsigned MS = 4;
  localparam int unsigned WW = 8;
  localparam int unsigned DT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [31:0]   wr_data = '0;
  logic          wr_ready;
  logic          load = 1'b0;
  logic          tile_valid;
  logic [31:0]   row;
  logic          row_valid;
`ifdef WEIGHT_FIFO_ERR_EN
  logic          err_underflow, err_gap;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_q[$];

  weight_fifo #(
    .MUL_SIZE    (MS),
    .WEIGHT_W    (WW),
    .DEPTH_TILES (DT)
  ) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .wr_valid_i               (wr_valid),
    .wr_data_i                (wr_data),
    .wr_ready_o               (wr_ready),
    .load_weights_i           (load),
    .weight_fifo_valid_output (tile_valid),
    .weight_row_o             (row),
`ifdef WEIGHT_FIFO_ERR_EN
    .err_underflow_o          (err_underflow),
    .err_gap_o                (err_gap),
`endif
    .weight_row_valid_o       (row_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Distinct byte per element so element ordering is also checked.
  function automatic logic [31:0] mk(input int unsigned v);
    return {8'(v + 48), 8'(v + 32), 8'(v + 16), 8'(v)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int unsigned v);
    wr_valid = 1'b1;
    wr_data  = mk(v);
    cyc();
    wr_valid = 1'b0;
  endtask

  // Monitor: every presented row must match the next queued expectation.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (row_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", row_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("row_data", row, e);
        end
      end
    end
  end

  initial begin
    // Reset
    cyc();
    cyc();
    chk("rst_ready", wr_ready, 1'b1);
    chk("rst_tile_valid", tile_valid, 1'b0);
    chk("rst_row_valid", row_valid, 1'b0);
    chk("rst_row", row, 32'h0);
    rst = 1'b0;
    cyc();

    // Fill one tile, then drain it
    wr(1); wr(2); wr(3);
    chk("fill_valid_early", tile_valid, 1'b0);
    wr(4);
    chk("fill_valid", tile_valid, 1'b1);
    load = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      exp_q.push_back(mk(i));
      cyc();
      if (i == 1) begin
        chk("claim_valid_low", tile_valid, 1'b0);
        chk("first_row_latency", row_valid, 1'b1);
      end
    end
    load = 1'b0;
    cyc();
    chk("drain_end_row_valid", row_valid, 1'b0);

    // Fill to full; extra write must be refused
    for (int unsigned i = 11; i <= 18; i++) begin
      wr(i);
      if (i == 17) chk("ready_at_7", wr_ready, 1'b1);
    end
    chk("full_ready", wr_ready, 1'b0);
    chk("full_tile_valid", tile_valid, 1'b1);
    wr(153);
    chk("full_ready_hold", wr_ready, 1'b0);

    // Pop row 0, slot frees next cycle; pop row 1 then pause two cycles
    load = 1'b1;
    exp_q.push_back(mk(11));
    cyc();
    chk("ready_after_pop", wr_ready, 1'b1);
    exp_q.push_back(mk(12));
    cyc();
    load = 1'b0;
    cyc();
    chk("gap_row_valid_1", row_valid, 1'b0);
    cyc();
    chk("gap_row_valid_2", row_valid, 1'b0);
`ifdef WEIGHT_FIFO_ERR_EN
    chk("err_gap", err_gap, 1'b1);
    chk("err_underflow_clear", err_underflow, 1'b0);
`endif
    load = 1'b1;
    exp_q.push_back(mk(13));
    cyc();
    exp_q.push_back(mk(14));
    cyc();
    load = 1'b0;

    // Simultaneous push and pop at occ=4 across the pointer wrap
    load = 1'b1;
    wr_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      wr_data = mk(21 + i);
      exp_q.push_back(mk(15 + i));
      cyc();
      chk("pp_ready", wr_ready, 1'b1);
      if (i == 0) chk("pp_claim_valid", tile_valid, 1'b0);
      if (i == 3) chk("pp_tile_done_valid", tile_valid, 1'b1);
    end
    wr_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      exp_q.push_back(mk(21 + i));
      cyc();
    end
    load = 1'b0;
    cyc();
    chk("empty_tile_valid", tile_valid, 1'b0);
    chk("empty_ready", wr_ready, 1'b1);

    // Underflow: request with empty FIFO
    load = 1'b1;
    cyc();
    chk("underflow_row_valid_1", row_valid, 1'b0);
    cyc();
    chk("underflow_row_valid_2", row_valid, 1'b0);
    load = 1'b0;
`ifdef WEIGHT_FIFO_ERR_EN
    chk("err_underflow", err_underflow, 1'b1);
`endif
    cyc();

    // Reset mid-drain
    wr(31); wr(32); wr(33); wr(34);
    load = 1'b1;
    exp_q.push_back(mk(31));
    cyc();
    exp_q.push_back(mk(32));
    cyc();
    load = 1'b0;
    rst  = 1'b1;
    cyc();
    chk("midrst_row_valid", row_valid, 1'b0);
    chk("midrst_row", row, 32'h0);
    chk("midrst_tile_valid", tile_valid, 1'b0);
    chk("midrst_ready", wr_ready, 1'b1);
`ifdef WEIGHT_FIFO_ERR_EN
    chk("midrst_err_gap", err_gap, 1'b0);
    chk("midrst_err_underflow", err_underflow, 1'b0);
`endif
    rst = 1'b0;
    cyc();
    chk("postrst_tile_valid", tile_valid, 1'b0);
    load = 1'b1;
    cyc();
    chk("postrst_no_pop", row_valid, 1'b0);
    load = 1'b0;
    cyc();
    cyc();
    chk("all_rows_seen", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_fifo.md
# weight_fifo

Tile-granular weight buffer feeding the systolic MAC array. Accepts weight rows from the host/DMA write port and releases them row-by-row while the control unit holds `load_weights_o`. Publishes `weight_fifo_valid_output`, which the weight control path uses to start a weight load. A tile is MUL_SIZE rows.

## Interface
- MUL_SIZE, tpu_package::MUL_SIZE, array dimension; rows per tile and weights per row
- WEIGHT_W, 8, bits per weight
- DEPTH_TILES, 4, tile capacity (power of two, ≥2)
- clk_i  in  1  clock. One clock; reset is synchronous and active-high.
- rst_i  in  1  synchronous, active-high reset
- wr_valid_i  in  1  write row offered
- wr_data_i  in  MUL_SIZE*WEIGHT_W  weight row, element 0 in LSBs
- wr_ready_o  out  1  row slot free
- load_weights_i  in  1  pop request, one row per cycle (driven by the control unit's load_weights_o)
- weight_fifo_valid_output  out  1  at least one complete, unclaimed tile stored
- weight_row_o  out  MUL_SIZE*WEIGHT_W  popped row
- weight_row_valid_o  out  1  weight_row_o is valid this cycle
- err_underflow_o, err_gap_o  out  1 each  sticky errors (only with WEIGHT_FIFO_ERR_EN)

## Operation
- Storage: DEPTH_TILES*MUL_SIZE rows, circular, write and read row pointers wrap modulo depth.
- Counters: occ (rows stored, 0..depth), wr_row (row within the tile being written), rd_row (row within the tile being drained), avail (complete, unclaimed tiles).
- Push: wr_valid_i && wr_ready_o. wr_ready_o = occ < depth. When wr_row wraps MUL_SIZE-1→0, avail increments.
- Read FSM:
  - IDLE→DRAIN when load_weights_i && avail>0. The tile is claimed: avail decrements and row 0 pops in the same cycle.
  - DRAIN: each cycle with load_weights_i high pops one row and increments rd_row. If load_weights_i is low, the FSM holds and nothing pops.
  - DRAIN→IDLE on popping row MUL_SIZE-1. The same cycle may not claim the next tile; the next claim is possible the following cycle.
- weight_fifo_valid_output = (avail>0), registered.
- Push and pop in the same cycle: both occur and occ is unchanged. A tile completing while another is claimed raises avail in the same cycle it would otherwise change; the net delta is summed.
- load_weights_i in IDLE with avail==0: ignored, nothing pops.
- rst_i clears pointers, counters and errors; FSM→IDLE; discards contents.

## Timing
- Reset values: wr_ready_o=1, weight_fifo_valid_output=0, weight_row_valid_o=0, weight_row_o=0, errors=0.
- Pop latency 1: a row popped in cycle N appears on weight_row_o with weight_row_valid_o in cycle N+1 (registered RAM read).
- Fill latency: the last row of a tile is written in cycle N; weight_fifo_valid_output is high in N+1.
- Claim: the claim of the last available tile in cycle N drives weight_fifo_valid_output low in N+1.
- wr_ready_o is registered from occ. A pop in cycle N frees a slot visible in N+1. No combinational ready path.
- Full-rate operation: one push and one pop per cycle are sustainable.

## Configuration
- WEIGHT_FIFO_ERR_EN defined:
  - err_underflow_o sets when load_weights_i is high in IDLE with avail==0.
  - err_gap_o sets when load_weights_i drops in DRAIN before row MUL_SIZE-1 is popped.
  - Both are sticky until rst_i.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

## Structure
- tpu_package: add WEIGHT_W, and a typedef weight_row_t (logic [MUL_SIZE*WEIGHT_W-1:0]). It is shared with the systolic array's weight input.
- FSM state enum is local (IDLE, DRAIN).
- One sub-module, weight_fifo_mem: simple dual-port RAM, one write port, one synchronous read port, no reset on the array.

## Test plan
Bench uses MUL_SIZE=4, DEPTH_TILES=2.
- Reset, then write rows 0x01..0x04 → weight_fifo_valid_output=1 one cycle after the 4th write. Hold load_weights_i 4 cycles → rows 0x01..0x04 out on consecutive cycles starting 1 cycle after the first pop; valid low after the claim.
- Write 8 rows → wr_ready_o=0 after the 8th. A 9th wr_valid_i is not accepted. Pop 1 row → wr_ready_o=1 next cycle.
- Simultaneous push and pop at occ=4 for 4 cycles → occ stays 4; data order preserved across the pointer wrap.
- Drop load_weights_i for 2 cycles after row 1 of a tile → output pauses, then resumes at row 2. With WEIGHT_FIFO_ERR_EN: err_gap_o=1.
- Assert load_weights_i with an empty FIFO → no weight_row_valid_o. With WEIGHT_FIFO_ERR_EN: err_underflow_o=1.
- Assert rst_i mid-drain → all outputs at reset values next cycle. The previously written tile is no longer reported.
